traffic_light_controller_mealy: RTL and testbench

TRAFFIC_LIGHT_CONTROLLER_MEALY -- requirements
Module: traffic_light_controller_mealy

---
 rtl/traffic_light_controller_mealy_pkg.sv | 34 +++
 rtl/traffic_light_controller_mealy_if.sv | 9 +
 rtl/traffic_light_controller_mealy_timer.sv | 27 ++
 rtl/traffic_light_controller_mealy.sv | 93 +++++++++
 tb/tb_traffic_light_controller_mealy.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_controller_mealy_pkg.sv
// Shared lamp encodings, controller state enumeration and per-state lamp decode
// for the highway/farm-road traffic light controller.
package tlc_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  typedef enum logic [2:0] {
    S_HG  = 3'd0,
    S_HY  = 3'd1,
    S_AR1 = 3'd2,
    S_FG  = 3'd3,
    S_FY  = 3'd4,
    S_AR2 = 3'd5
  } tlc_state_e;

  function automatic logic [2:0] hwy_lamp(tlc_state_e s);
    case (s)
      S_HG:    hwy_lamp = LAMP_GREEN;
      S_HY:    hwy_lamp = LAMP_YELLOW;
      default: hwy_lamp = LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] farm_lamp(tlc_state_e s);
    case (s)
      S_FG:    farm_lamp = LAMP_GREEN;
      S_FY:    farm_lamp = LAMP_YELLOW;
      default: farm_lamp = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_controller_mealy_if.sv
// Road-side signal bundle: farm-road vehicle sensor in, both lamp heads out.
interface traffic_light_controller_mealy_if;
  logic       sensor;
  logic [2:0] light_highway;
  logic [2:0] light_farmway;

  modport master (output sensor, input light_highway, input light_farmway);
  modport slave  (input sensor, output light_highway, output light_farmway);
endinterface

// File: rtl/traffic_light_controller_mealy_timer.sv
// Phase timer: loads duration-1 on a strobe, counts down and holds at zero.
module tlc_timer #(
  parameter int             W           = 4,
  parameter logic [W-1:0]   RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rstn)
      count_reg <= RESET_VALUE;
    else if (load)
      count_reg <= load_value;
    else if (dec && (count_reg != '0))
      count_reg <= count_reg - W'(1);
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/traffic_light_controller_mealy.sv
// Mealy highway/farm-road traffic light controller. Optional macro
// TLC_SENSOR_SYNC_EN inserts a two-flop synchronizer on the sensor input.
module traffic_light_controller_mealy
  import tlc_pkg::*;
#(
  parameter int HWY_MIN_GREEN  = 16,
  parameter int YELLOW_CYCLES  = 4,
  parameter int ALL_RED_CYCLES = 2,
  parameter int FARM_MAX_GREEN = 12
) (
  input  logic clk,
  input  logic rstn,
  traffic_light_controller_mealy_if.slave bus
);

  localparam int MAX_AB  = (HWY_MIN_GREEN > YELLOW_CYCLES) ? HWY_MIN_GREEN : YELLOW_CYCLES;
  localparam int MAX_CD  = (ALL_RED_CYCLES > FARM_MAX_GREEN) ? ALL_RED_CYCLES : FARM_MAX_GREEN;
  localparam int MAX_DUR = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW      = $clog2(MAX_DUR);

  tlc_state_e    state_reg;
  tlc_state_e    state_next;
  logic          sensor_q;
  logic          timer_load;
  logic          timer_done;
  logic [TW-1:0] timer_load_value;

`ifdef TLC_SENSOR_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (!rstn)
      sync_reg <= '0;
    else
      sync_reg <= {sync_reg[0], bus.sensor};
  end

  assign sensor_q = sync_reg[1];
`else
  assign sensor_q = bus.sensor;
`endif

  function automatic logic [TW-1:0] reload_of(tlc_state_e s);
    case (s)
      S_HY, S_FY:   reload_of = TW'(YELLOW_CYCLES - 1);
      S_AR1, S_AR2: reload_of = TW'(ALL_RED_CYCLES - 1);
      S_FG:         reload_of = TW'(FARM_MAX_GREEN - 1);
      default:      reload_of = TW'(HWY_MIN_GREEN - 1);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn)
      state_reg <= S_HG;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_HG:    if (timer_done && sensor_q)   state_next = S_HY;
      S_HY:    if (timer_done)               state_next = S_AR1;
      S_AR1:   if (timer_done)               state_next = S_FG;
      S_FG:    if (!sensor_q || timer_done)  state_next = S_FY;
      S_FY:    if (timer_done)               state_next = S_AR2;
      S_AR2:   if (timer_done)               state_next = S_HG;
      default:                               state_next = S_HG;
    endcase
  end

  // Every state change is a state entry, so it always reloads the timer.
  assign timer_load       = (state_next != state_reg);
  assign timer_load_value = reload_of(state_next);

  tlc_timer #(
    .W           (TW),
    .RESET_VALUE (TW'(HWY_MIN_GREEN - 1))
  ) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load       (timer_load),
    .load_value (timer_load_value),
    .dec        (1'b1),
    .done       (timer_done)
  );

  // Lamps follow state_next so a firing transition (reset included) shows its
  // destination lamps in the same cycle.
  assign bus.light_highway = rstn ? hwy_lamp(state_next)  : LAMP_GREEN;
  assign bus.light_farmway = rstn ? farm_lamp(state_next) : LAMP_RED;

endmodule

// File: tb/tb_traffic_light_controller_mealy.sv
// Self-checking bench: phase/age reference model compared every cycle, plus
// hand-computed lamp traces for the key timing scenarios.
module tb_traffic_light_controller_mealy;
  import tlc_pkg::*;

  localparam int HWY  = 16;
  localparam int YEL  = 4;
  localparam int AR   = 2;
  localparam int FARM = 12;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  traffic_light_controller_mealy_if bus ();

  traffic_light_controller_mealy #(
    .HWY_MIN_GREEN  (HWY),
    .YELLOW_CYCLES  (YEL),
    .ALL_RED_CYCLES (AR),
    .FARM_MAX_GREEN (FARM)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Reference model: phase index 0..5 = HG,HY,AR1,FG,FY,AR2 and cycles spent in it.
  int   m_phase = 0;
  int   m_age   = 0;
  bit   armed   = 1'b0;
  logic s1 = 1'b0;
  logic s2 = 1'b0;
  logic m_sens;
  int   shown;

  function automatic bit leaves(int ph, int age, logic s);
    case (ph)
      0:       return (age >= HWY - 1) && s;
      1, 4:    return age >= YEL - 1;
      2, 5:    return age >= AR - 1;
      3:       return !s || (age >= FARM - 1);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] hw_of(int ph);
    return (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] fm_of(int ph);
    return (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
  endfunction

  always_comb begin
`ifdef TLC_SENSOR_SYNC_EN
    m_sens = s2;
`else
    m_sens = bus.sensor;
`endif
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_phase <= 0;
      m_age   <= 0;
      armed   <= 1'b1;
      s1      <= 1'b0;
      s2      <= 1'b0;
    end else begin
      s1 <= bus.sensor;
      s2 <= s1;
      if (leaves(m_phase, m_age, m_sens)) begin
        m_phase <= (m_phase + 1) % 6;
        m_age   <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      shown = !rstn ? 0 : (leaves(m_phase, m_age, m_sens) ? (m_phase + 1) % 6 : m_phase);
      checks++;
      if (bus.light_highway !== hw_of(shown) || bus.light_farmway !== fm_of(shown)) begin
        errors++;
        $display("FAIL model_cmp t=%0t got hwy=%b farm=%b want hwy=%b farm=%b",
                 $time, bus.light_highway, bus.light_farmway, hw_of(shown), fm_of(shown));
      end
      checks++;
      if (!$onehot(bus.light_highway) || !$onehot(bus.light_farmway) ||
          (bus.light_highway != LAMP_RED && bus.light_farmway != LAMP_RED)) begin
        errors++;
        $display("FAIL safety t=%0t got hwy=%b farm=%b want one-hot with a red",
                 $time, bus.light_highway, bus.light_farmway);
      end
    end
  end

  task automatic lit_check(input string name, input logic [2:0] eh, input logic [2:0] ef);
    checks++;
    if (bus.light_highway !== eh || bus.light_farmway !== ef) begin
      errors++;
      $display("FAIL %s t=%0t got %b/%b want %b/%b", name, $time,
               bus.light_highway, bus.light_farmway, eh, ef);
    end
  endtask

  // Hand-derived lamps for sensor=1 from reset; idx 0 is the last reset-low cycle.
  function automatic logic [5:0] trace_exp(int idx);
    if (idx <= 15)      return {3'b001, 3'b100};
    else if (idx <= 19) return {3'b010, 3'b100};
    else if (idx <= 21) return {3'b100, 3'b100};
    else if (idx <= 33) return {3'b100, 3'b001};
    else if (idx <= 37) return {3'b100, 3'b010};
    else if (idx <= 39) return {3'b100, 3'b100};
    else if (idx <= 55) return {3'b001, 3'b100};
    else                return {3'b010, 3'b100};
  endfunction

  // Two reset edges with sensor=1; returns at the start of the first released cycle.
  task automatic reset_run();
    @(posedge clk); #2; rstn = 1'b0; bus.sensor = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2; rstn = 1'b1;
  endtask

  initial begin
    logic [5:0] e;
    int         n;
    bus.sensor = 1'b0;
    rstn       = 1'b0;

    repeat (10) @(posedge clk);
    #2; rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lit_check("idle_hg", 3'b001, 3'b100);
    end
    $display("txn idle: 100 cycles sensor=0 after reset");

    @(posedge clk); #2; rstn = 1'b0; bus.sensor = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    e = trace_exp(0);
    lit_check("trace_idx0", e[5:3], e[2:0]);
    @(posedge clk); #2; rstn = 1'b1;
    for (int idx = 1; idx <= 56; idx++) begin
      @(negedge clk);
      e = trace_exp(idx);
      lit_check($sformatf("trace_idx%0d", idx), e[5:3], e[2:0]);
    end
    $display("txn full_cycle: sensor held 1 through HG/HY/AR1/FG/FY/AR2/HG");

    reset_run();
    repeat (25) @(posedge clk);
    #2; bus.sensor = 1'b0;
    @(negedge clk);
    lit_check("fg_drop_mealy", 3'b100, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit_check("fg_drop_yellow", 3'b100, 3'b010);
    end
    @(negedge clk);
    lit_check("fg_drop_allred", 3'b100, 3'b100);
    $display("txn farm_early_end: sensor dropped in 5th farm-green cycle");

    reset_run();
    repeat (27) @(posedge clk);
    #2; rstn = 1'b0;
    @(negedge clk);
    lit_check("rst_in_fg_low", 3'b001, 3'b100);
    @(posedge clk); #2; rstn = 1'b1;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.light_highway == 3'b001 && bus.light_farmway == 3'b100) n++;
      else break;
    end
    checks++;
    if (n != HWY) begin
      errors++;
      $display("FAIL rst_in_fg_green_len got %0d want %0d", n, HWY);
    end
    lit_check("rst_in_fg_then_yellow", 3'b010, 3'b100);
    $display("txn reset_in_fg: highway green %0d cycles after reset pulse", n);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 5) == 0) bus.sensor = ~bus.sensor;
      rstn = ($urandom_range(0, 399) != 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    $display("txn random: 3000 cycles random sensor with sporadic resets");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
